// File: rtl/box_datapath.sv
// Box position/direction state plus a SIZE x SIZE row-major pixel walker feeding the VGA adapter.
// All outputs are registered one cycle behind the pixel counter; there is no backpressure.
module box_datapath #(
  parameter int          SIZE   = 4,
  parameter int          X_MAX  = 160,
  parameter int          Y_MAX  = 120,
  parameter int          X_INIT = 78,
  parameter int          Y_INIT = 10,
  parameter logic [2:0]  COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       datapath_en,
  input  logic [1:0] op,
  input  logic       plot,
  input  logic       load_coord,
  input  logic       move_en,
  input  logic [1:0] steer,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot_out,
  output logic       done,
  output logic       touch_edge
);

  localparam int         LOG  = $clog2(SIZE);
  localparam int         CW   = 2 * LOG;
  localparam logic [7:0] XLIM = 8'(X_MAX - SIZE);
  localparam logic [6:0] YLIM = 7'(Y_MAX - SIZE);

  logic [7:0]    x_reg, x_nxt;
  logic [6:0]    y_reg, y_nxt;
  logic          dir_x, dir_x_nxt;
  logic          dir_y, dir_y_nxt;
  logic [CW-1:0] cnt;
  logic [LOG-1:0] dx, dy;
  logic [2:0]    colour_sel;
  logic          step;

  assign dx   = cnt[LOG-1:0];
  assign dy   = cnt[CW-1:LOG];
  // Position is frozen while a walk is in progress.
  assign step = load_coord & ~datapath_en;

  always_comb begin
    colour_sel = 3'b000;
    case (op)
      2'b00:   colour_sel = COLOUR;
      2'b10:   colour_sel = 3'b100;
      default: colour_sel = 3'b000;
    endcase
  end

  always_comb begin
    x_nxt     = x_reg;
    y_nxt     = y_reg;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    if (step) begin
      if (dir_x) begin
        if (x_reg == XLIM) begin
          dir_x_nxt = 1'b0;
          x_nxt     = x_reg - 8'd1;
        end else begin
          x_nxt = x_reg + 8'd1;
        end
      end else if (x_reg == 8'd0) begin
        dir_x_nxt = 1'b1;
        x_nxt     = x_reg + 8'd1;
      end else begin
        x_nxt = x_reg - 8'd1;
      end
      if (dir_y) begin
        if (y_reg == YLIM) begin
          dir_y_nxt = 1'b0;
          y_nxt     = y_reg - 7'd1;
        end else begin
          y_nxt = y_reg + 7'd1;
        end
      end else if (y_reg == 7'd0) begin
        dir_y_nxt = 1'b1;
        y_nxt     = y_reg + 7'd1;
      end else begin
        y_nxt = y_reg - 7'd1;
      end
    end
    // Steering overrides the bounce direction; the step above used the old dir_x.
    if (move_en) begin
      case (steer)
        2'b01:   dir_x_nxt = 1'b0;
        2'b10:   dir_x_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg      <= 8'(X_INIT);
      y_reg      <= 7'(Y_INIT);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      touch_edge <= 1'b0;
    end else begin
      x_reg <= x_nxt;
      y_reg <= y_nxt;
      dir_x <= dir_x_nxt;
      dir_y <= dir_y_nxt;
      if (step && (y_nxt == YLIM)) touch_edge <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= 3'b000;
      plot_out   <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= datapath_en ? cnt + 1'b1 : '0;
      x_out      <= x_reg + {{(8-LOG){1'b0}}, dx};
      y_out      <= y_reg + {{(7-LOG){1'b0}}, dy};
      colour_out <= colour_sel;
      plot_out   <= plot & datapath_en;
      done       <= datapath_en & (&cnt);
    end
  end

endmodule

// File: doc/box_datapath.md
# box_datapath

Datapath stage driven directly by the game control FSM. It holds the moving box's position and direction. When the FSM sequences a draw or erase, it walks the box's SIZE×SIZE pixels and presents one pixel per cycle (x, y, colour, plot) to the VGA adapter. It also reports completion (`done`) and the bottom-edge condition (`touch_edge`) back to the FSM.

## Interface
Parameters:
- SIZE, 4: box side in pixels; power of two, 2..8
- X_MAX, 160: screen width in pixels
- Y_MAX, 120: screen height in pixels
- X_INIT, 78: reset x of the box's top-left corner
- Y_INIT, 10: reset y of the box's top-left corner
- COLOUR, 3'b111: draw colour

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- datapath_en  in  1  run the pixel walk
- op  in  2  00 draw (COLOUR), 01 erase (3'b000), 10 game-over (3'b100), 11 reserved (3'b000)
- plot  in  1  FSM plot request; qualified and registered to plot_out
- load_coord  in  1  advance position by one step
- move_en  in  1  enables sampling of steer
- steer  in  2  [0] steer left, [1] steer right
- x_out  out  8  pixel x to VGA adapter
- y_out  out  7  pixel y to VGA adapter
- colour_out  out  3  pixel colour
- plot_out  out  1  VGA write enable
- done  out  1  one-cycle pulse with the last pixel of a walk
- touch_edge  out  1  sticky; box has reached the bottom edge

## Operation
- State registers:
  - x_reg[7:0], y_reg[6:0]: top-left corner
  - dir_x, dir_y: 1 = +, 0 = −
  - cnt: pixel counter, width log2(SIZE²)
  - touch_edge flag
- Pixel walk:
  - While datapath_en=1, cnt increments by 1 each cycle.
  - cnt wraps SIZE²−1 → 0.
  - When datapath_en=0, cnt is forced to 0.
  - Pixel offset: dx = cnt[log2(SIZE)−1:0], dy = cnt upper bits (row-major).
- Output register, loaded every cycle:
  - x_out ← x_reg + dx
  - y_out ← y_reg + dy
  - colour_out ← colour selected by op
  - plot_out ← plot & datapath_en
  - done ← datapath_en & (cnt == SIZE²−1)
- Steering:
  - When move_en=1 and steer=01: dir_x ← 0.
  - When move_en=1 and steer=10: dir_x ← 1.
  - steer=00 or 11: no change.
  - move_en=0: steer is ignored.
- Position step on load_coord=1 with datapath_en=0:
  - x: if dir_x=1 and x_reg == X_MAX−SIZE, then dir_x ← 0 and x_reg ← x_reg−1.
  - x: if dir_x=0 and x_reg == 0, then dir_x ← 1 and x_reg ← x_reg+1.
  - x: otherwise x_reg ± 1.
  - y: same rule against 0 and Y_MAX−SIZE.
  - If the new y_reg == Y_MAX−SIZE, touch_edge ← 1. It stays 1 until reset.
- Steering and load_coord in the same cycle: the steering update wins for dir_x. The step uses the old dir_x.
- load_coord while datapath_en=1 is ignored, so position is frozen during a walk.
- Coordinates never leave [0, X_MAX−SIZE] × [0, Y_MAX−SIZE].

## Timing
- Reset (asynchronous, immediate):
  - x_reg=X_INIT, y_reg=Y_INIT, dir_x=1, dir_y=1, cnt=0
  - x_out=0, y_out=0, colour_out=0, plot_out=0, done=0, touch_edge=0
- Outputs are registered with 1-cycle latency.
  - The pixel for cnt=k appears the cycle after cnt=k.
- A full walk takes SIZE² cycles of datapath_en.
  - done is high in the cycle the last pixel is presented, i.e. SIZE² cycles after datapath_en rises.
- If datapath_en drops mid-walk:
  - cnt returns to 0; the next walk restarts at pixel 0.
  - No done pulse is produced.
- A position update is visible to the walk starting on the next cycle.
- Reset asserted mid-walk aborts it; no done pulse is produced.

## Test plan
- Reset, then op=00 and datapath_en=plot=1 for 16 cycles (SIZE=4) → pixels (78,10),(79,10)…(81,13), colour 111, plot_out=1 each cycle; done only on the (81,13) cycle.
- op=01 walk → same coordinates, colour 000.
- Drop datapath_en after 5 cycles, then re-enable → restart at (78,10); no done pulse.
- x_reg=X_MAX−SIZE (156), dir_x=1, pulse load_coord → x_reg=155, dir_x=0.
  - Repeat at x_reg=0 → x_reg=1, dir_x=1.
- From Y_INIT, repeat load_coord until y_reg=116 → touch_edge=1, staying 1 after the bounce back to y_reg=115.
- move_en=1, steer=01 together with load_coord at x_reg=100, dir_x=1 → x_reg=101, dir_x=0.
  - steer=11 → dir_x unchanged.
  - move_en=0, steer=01 → ignored.
